// File: rtl/disp_pkg.sv
// Shared constants and state type for the binary-to-BCD display controller.
package disp_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [9:0] BCD_MAX  = 10'd999;
    localparam int         BCD_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 when the digit would overflow on the next shift.
module bcd_add3
    import disp_pkg::*;
(
    input  logic [BCD_W-1:0] nib,
    output logic [BCD_W-1:0] fixed
);
    assign fixed = (nib >= BCD_W'(5)) ? nib + BCD_W'(3) : nib;
endmodule

// File: rtl/bin2bcd_ctrl.sv
// Iterative shift-and-add-3 binary to 3-digit BCD converter with start/busy/done handshake.
module bin2bcd_ctrl
    import disp_pkg::*;
#(
    parameter int W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     value,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [BCD_W-1:0] N1,
    output logic [BCD_W-1:0] N2,
    output logic [BCD_W-1:0] N3
);
    localparam int CW = $clog2(W + 1);

    state_t          state;
    logic [W-1:0]    sreg;
    logic [11:0]     scratch;
    logic [11:0]     fixed;
    logic [CW-1:0]   cnt;
    logic            over;

    // Only a full 10-bit input can exceed 999; narrower widths never clamp.
    assign over = (W >= 10) && (32'(value) > 32'(BCD_MAX));

    for (genvar g = 0; g < 3; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib  (scratch[g*BCD_W +: BCD_W]),
            .fixed(fixed[g*BCD_W +: BCD_W])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sreg    <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            N1      <= '0;
            N2      <= '0;
            N3      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy    <= 1'b1;
                        scratch <= '0;
                        cnt     <= '0;
                        state   <= SHIFT;
                        if (over) begin
                            sreg <= W'(BCD_MAX);
                            ovf  <= 1'b1;
                        end else begin
                            sreg <= value;
                            ovf  <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    scratch <= {fixed[10:0], sreg[W-1]};
                    sreg    <= {sreg[W-2:0], 1'b0};
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(W - 1))
                        state <= DONE;
                end
                DONE: begin
                    // Digits update only here so the display never sees partial results.
                    N1    <= scratch[3:0];
                    N2    <= scratch[7:4];
                    N3    <= scratch[11:8];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_ctrl.sv
// Self-checking bench for bin2bcd_ctrl: vector table, random values vs arithmetic model, corner sequences.
module tb_bin2bcd_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] value;
    logic       busy, done, ovf;
    logic [3:0] N1, N2, N3;

    int checks = 0;
    int errors = 0;

    bin2bcd_ctrl #(.W(10)) dut (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy), .done(done), .ovf(ovf), .N1(N1), .N2(N2), .N3(N3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  v;
        logic [11:0] digits;
        logic        ovf;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [12:0] model(input int v);
        int c;
        c = (v > 999) ? 999 : v;
        return {v > 999, 4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic int outs();
        return int'({busy, done, ovf, N3, N2, N1});
    endfunction

    // Start a conversion and follow it to its done pulse, checking handshake timing.
    task automatic convert(input logic [9:0] v, input string tag);
        int lat, bcnt;
        @(negedge clk); value = v; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk); lat++;
        end
        chk({tag, " latency"}, lat, 11);
        chk({tag, " busy_cycles"}, bcnt, 11);
        chk({tag, " busy_at_done"}, int'(busy), 0);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, int'({busy, done}), 0);
    endtask

    vec_t vecs[7];

    initial begin
        int lat, nd, last, gap_err;
        logic [12:0] m;
        logic [9:0] rv;

        vecs[0] = '{10'd259,  12'h259, 1'b0};
        vecs[1] = '{10'd1023, 12'h999, 1'b1};
        vecs[2] = '{10'd7,    12'h007, 1'b0};
        vecs[3] = '{10'd0,    12'h000, 1'b0};
        vecs[4] = '{10'd999,  12'h999, 1'b0};
        vecs[5] = '{10'd1000, 12'h999, 1'b1};
        vecs[6] = '{10'd512,  12'h512, 1'b0};

        reset = 1'b1; start = 1'b0; value = '0;
        #23;
        chk("in_reset outputs", outs(), 0);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle after reset", outs(), 0);
        end

        foreach (vecs[i]) begin
            convert(vecs[i].v, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d digits", i), int'({N3, N2, N1}), int'(vecs[i].digits));
            chk($sformatf("vec%0d ovf", i), int'(ovf), int'(vecs[i].ovf));
        end

        for (int i = 0; i < 25; i++) begin
            rv = 10'($urandom_range(0, 1023));
            convert(rv, $sformatf("rnd%0d", i));
            m = model(int'(rv));
            chk($sformatf("rnd%0d(%0d) result", i, rv), int'({ovf, N3, N2, N1}), int'(m));
        end

        // Start held high: back-to-back conversions every 12 cycles.
        @(negedge clk); value = 10'd0; start = 1'b1;
        @(posedge clk);
        nd = 0; last = -1; gap_err = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                if (last >= 0 && i - last != 12) gap_err++;
                if (last < 0 && i != 11) gap_err++;
                last = i; nd++;
            end
        end
        start = 1'b0;
        chk("cont done_count", nd, 5);
        chk("cont gap_errors", gap_err, 0);
        chk("cont digits", int'({ovf, N3, N2, N1}), 0);
        repeat (3) @(negedge clk);
        chk("cont idle after", int'({busy, done}), 0);

        // Start asserted mid-conversion must be dropped, not queued.
        @(negedge clk); value = 10'd500; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk); lat++;
            if (lat == 3) begin value = 10'd123; start = 1'b1; end
            if (lat == 4) start = 1'b0;
        end
        chk("ignore latency", lat, 11);
        chk("ignore digits", int'({ovf, N3, N2, N1}), 13'h0500);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("ignore no_second_conv", nd, 0);
        chk("ignore digits held", int'({ovf, N3, N2, N1}), 13'h0500);

        // Reset mid-conversion discards the pending result.
        @(negedge clk); value = 10'd850; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset outputs", outs(), 0);
        repeat (2) @(negedge clk);
        chk("midreset held", outs(), 0);
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("midreset no_done", nd, 0);
        chk("midreset digits", int'({ovf, N3, N2, N1}), 0);
        convert(10'd42, "post_reset");
        chk("post_reset digits", int'({ovf, N3, N2, N1}), 13'h0042);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
